// File: rtl/bidsr_pkg.sv
// -----------------------------------------------------------------------------
// bidsr_pkg
// Shared definitions for the bidirectional shift register slice:
//   ser_state_t    - serializer control states (IDLE, SHIFT, GAP)
//   DIR_LSB_FIRST  - word sent LSB first; downstream register shifts right
//   DIR_MSB_FIRST  - word sent MSB first; downstream register shifts left
// -----------------------------------------------------------------------------
package bidsr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } ser_state_t;

    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;

endpackage

// File: rtl/bidsr_serializer.sv
// -----------------------------------------------------------------------------
// bidsr_serializer
// Parallel-to-serial loader feeding the 4-bit bidirectional shift register.
// A word accepted over valid/ready is emitted one bit per clock, each bit
// paired with the shift direction that lets the downstream register rebuild
// the word in its original bit positions.
//
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous, active-high reset
//   din        - parallel word (WIDTH bits)
//   dir        - 0: LSB first, 1: MSB first
//   din_valid  - din/dir valid
//   din_ready  - word can be accepted this cycle (decoded, not registered)
//   ser_out    - serial data to downstream s_in
//   mode_out   - direction for the current bit to downstream mode
//   ser_valid  - ser_out/mode_out carry a word bit
//   word_done  - one-cycle pulse alongside the last bit of a word
// -----------------------------------------------------------------------------
module bidsr_serializer
    import bidsr_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             dir,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ser_out,
    output logic             mode_out,
    output logic             ser_valid,
    output logic             word_done
);

    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
    localparam bit              GAPLESS  = (GAP_CYCLES == 0);

    ser_state_t       state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             ser_out_q, ser_out_d;
    logic             mode_out_q, mode_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             word_done_q, word_done_d;

    logic             last_bit_s;
    logic             accept_s;
    logic             gap_done_s;

    assign last_bit_s = (state_q == SHIFT) && (cnt_q == CNT_LAST);
    assign accept_s   = din_valid && din_ready;

    // Ready decode: always ready in IDLE; in SHIFT only on the final bit when
    // words may stream back-to-back; never while reset is asserted.
    always_comb begin
        din_ready = 1'b0;
        if (rst) begin
            din_ready = 1'b0;
        end else begin
            case (state_q)
                IDLE:    din_ready = 1'b1;
                SHIFT:   din_ready = GAPLESS && last_bit_s;
                default: din_ready = 1'b0;
            endcase
        end
    end

    // Idle-gap counter exists only when a gap is configured.
    generate
        if (GAP_CYCLES > 0) begin : g_gap
            localparam int            GW       = $clog2(GAP_CYCLES + 1);
            localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

            logic [GW-1:0] gap_q, gap_d;

            // Count cycles spent in GAP; cleared whenever outside GAP so each
            // gap starts from zero.
            always_comb begin
                gap_d = '0;
                if (state_q == GAP) begin
                    gap_d = gap_q + GW'(1);
                end else begin
                    gap_d = '0;
                end
            end

            // Gap counter register.
            always_ff @(posedge clk) begin
                if (rst) begin
                    gap_q <= '0;
                end else begin
                    gap_q <= gap_d;
                end
            end

            assign gap_done_s = (state_q == GAP) && (gap_q == GAP_LAST);
        end else begin : g_no_gap
            assign gap_done_s = 1'b0;
        end
    endgenerate

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        ser_out_d   = 1'b0;
        mode_out_d  = mode_out_q;
        ser_valid_d = 1'b0;
        word_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    sr_d    = din;
                    dir_d   = dir;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end

            SHIFT: begin
                // Bit and its direction leave on the same edge, so the
                // downstream stage never pairs an old bit with a new mode.
                if (dir_q == DIR_MSB_FIRST) begin
                    ser_out_d = sr_q[WIDTH-1];
                    sr_d      = {sr_q[WIDTH-2:0], 1'b0};
                end else begin
                    ser_out_d = sr_q[0];
                    sr_d      = {1'b0, sr_q[WIDTH-1:1]};
                end
                mode_out_d  = dir_q;
                ser_valid_d = 1'b1;
                cnt_d       = cnt_q + CW'(1);

                if (last_bit_s) begin
                    word_done_d = 1'b1;
                    if (!GAPLESS) begin
                        state_d = GAP;
                    end else if (accept_s) begin
                        // Gapless hand-over: next word loads on the edge
                        // that emits the current last bit.
                        sr_d    = din;
                        dir_d   = dir;
                        cnt_d   = '0;
                        state_d = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = SHIFT;
                end
            end

            GAP: begin
                if (gap_done_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = GAP;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            ser_out_q   <= 1'b0;
            mode_out_q  <= 1'b0;
            ser_valid_q <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            ser_out_q   <= ser_out_d;
            mode_out_q  <= mode_out_d;
            ser_valid_q <= ser_valid_d;
            word_done_q <= word_done_d;
        end
    end

    assign ser_out   = ser_out_q;
    assign mode_out  = mode_out_q;
    assign ser_valid = ser_valid_q;
    assign word_done = word_done_q;

endmodule
